// File: rtl/reg_file_shadow_pkg.sv
// Shared definitions for the shadowed register file (package baej_pkg).
// Default sizes, the register-frame type and the stack error causes.
// Optional build macro used by the top level: REGFILE_BYPASS_EN.
package baej_pkg;

  localparam int DATA_W      = 16;
  localparam int NUM_REGS    = 8;
  localparam int ADDR_W      = 3;
  localparam int STACK_DEPTH = 4;

  // sp counts 0..STACK_DEPTH inclusive, so it needs one bit more than an index
  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = IDX_W + 1;

  // One saved frame: r1..r(NUM_REGS-1); r0 is hard-wired zero and never stored
  typedef logic [1:NUM_REGS-1][DATA_W-1:0] frame_t;

  // Reason a stack request was refused
  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    OVF        = 2'd1,
    UDF        = 2'd2,
    CONFLICT   = 2'd3
  } err_cause_e;

endpackage

// File: rtl/reg_file_shadow_if.sv
// Control-unit to register-file bus.
// Strobes are single-cycle commands sampled on the rising clock edge; there is
// no valid/ready back-pressure: every strobe is accepted in the cycle it is high.
// master: control unit side, slave: register file side.
interface reg_file_shadow_if;
  import baej_pkg::*;

  logic              RegR1;
  logic              RegR2;
  logic [ADDR_W-1:0] rd1_addr;
  logic [ADDR_W-1:0] rd2_addr;
  logic              RegW1;
  logic              RegW2;
  logic [ADDR_W-1:0] wr1_addr;
  logic [ADDR_W-1:0] wr2_addr;
  logic [DATA_W-1:0] wr1_data;
  logic [DATA_W-1:0] wr2_data;
  logic              backup;
  logic              restore;
  logic [DATA_W-1:0] rd1_data;
  logic [DATA_W-1:0] rd2_data;
  logic [SP_W-1:0]   sp;
  logic              stack_full;
  logic              stack_empty;
  logic              stack_err;

  modport master (
    output RegR1, RegR2, rd1_addr, rd2_addr,
    output RegW1, RegW2, wr1_addr, wr2_addr, wr1_data, wr2_data,
    output backup, restore,
    input  rd1_data, rd2_data, sp, stack_full, stack_empty, stack_err
  );

  modport slave (
    input  RegR1, RegR2, rd1_addr, rd2_addr,
    input  RegW1, RegW2, wr1_addr, wr2_addr, wr1_data, wr2_data,
    input  backup, restore,
    output rd1_data, rd2_data, sp, stack_full, stack_empty, stack_err
  );

endinterface

// File: rtl/reg_file_shadow_shadow_stack.sv
// Shadow stack of full register frames.
// push saves frame_in at frames[sp]; pop presents frames[sp-1] on frame_out
// and asserts pop_ok for the cycle the live registers must take it.
// Refused requests (overflow, underflow, push+pop together) set a sticky err.
module shadow_stack
  import baej_pkg::*;
(
  input  logic            clk,
  input  logic            Reset,
  input  logic            push,
  input  logic            pop,
  input  frame_t          frame_in,
  output frame_t          frame_out,
  output logic            pop_ok,
  output logic [SP_W-1:0] sp,
  output logic            full,
  output logic            empty,
  output logic            err
);

  frame_t          frames [STACK_DEPTH];
  logic [SP_W-1:0] sp_q;
  logic            err_q;
  logic            do_push;
  logic            do_pop;
  err_cause_e      cause;
  logic [IDX_W-1:0] top_idx;

  assign full  = (sp_q == SP_W'(STACK_DEPTH));
  assign empty = (sp_q == '0);

  // Index of the topmost saved frame; modulo arithmetic on the low bits is
  // exact because STACK_DEPTH is a power of two and it is only used when sp>0
  assign top_idx   = sp_q[IDX_W-1:0] - IDX_W'(1);
  assign frame_out = frames[top_idx];

  // Decide whether the request is honoured and classify any refusal
  always_comb begin
    do_push = 1'b0;
    do_pop  = 1'b0;
    cause   = CAUSE_NONE;
    if (push && pop) begin
      cause = CONFLICT;
    end else if (push) begin
      if (full) cause = OVF;
      else      do_push = 1'b1;
    end else if (pop) begin
      if (empty) cause = UDF;
      else       do_pop = 1'b1;
    end
  end

  assign pop_ok = do_pop;

  // Frame count and sticky error flag
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      sp_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (do_push)     sp_q <= sp_q + SP_W'(1);
      else if (do_pop) sp_q <= sp_q - SP_W'(1);
      if (cause != CAUSE_NONE) err_q <= 1'b1;
    end
  end

  // Frame storage, written only on an accepted push
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < STACK_DEPTH; i++) frames[i] <= '0;
    end else if (do_push) begin
      frames[sp_q[IDX_W-1:0]] <= frame_in;
    end
  end

  assign sp  = sp_q;
  assign err = err_q;

endmodule

// File: rtl/reg_file_shadow.sv
// Register file with two registered read ports, two write ports and a
// hardware shadow stack (backup pushes the live frame, restore pops it).
// r0 reads as zero and ignores writes; write port 2 wins on an address clash.
// Build option REGFILE_BYPASS_EN: same-cycle write data is forwarded to reads.
module reg_file_shadow
  import baej_pkg::*;
(
  input  logic          clk,
  input  logic          Reset,
  reg_file_shadow_if.slave bus
);

  frame_t            live;
  frame_t            frame_out;
  logic              pop_ok;
  logic [DATA_W-1:0] rd1_next;
  logic [DATA_W-1:0] rd2_next;
  logic [DATA_W-1:0] rd1_q;
  logic [DATA_W-1:0] rd2_q;
  logic [SP_W-1:0]   sp_w;
  logic              full_w;
  logic              empty_w;
  logic              err_w;

  shadow_stack u_stack (
    .clk       (clk),
    .Reset     (Reset),
    .push      (bus.backup),
    .pop       (bus.restore),
    .frame_in  (live),
    .frame_out (frame_out),
    .pop_ok    (pop_ok),
    .sp        (sp_w),
    .full      (full_w),
    .empty     (empty_w),
    .err       (err_w)
  );

  // Live registers: restore first, then writes on top, port 2 last so it wins
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      live <= '0;
    end else begin
      if (pop_ok) live <= frame_out;
      if (bus.RegW1 && bus.wr1_addr != '0) live[bus.wr1_addr] <= bus.wr1_data;
      if (bus.RegW2 && bus.wr2_addr != '0) live[bus.wr2_addr] <= bus.wr2_data;
    end
  end

  // Read-port mux: current register contents, optionally forwarded write data
  always_comb begin
    rd1_next = (bus.rd1_addr == '0) ? '0 : live[bus.rd1_addr];
    rd2_next = (bus.rd2_addr == '0) ? '0 : live[bus.rd2_addr];
`ifdef REGFILE_BYPASS_EN
    if (bus.RegW1 && bus.wr1_addr == bus.rd1_addr && bus.rd1_addr != '0) rd1_next = bus.wr1_data;
    if (bus.RegW2 && bus.wr2_addr == bus.rd1_addr && bus.rd1_addr != '0) rd1_next = bus.wr2_data;
    if (bus.RegW1 && bus.wr1_addr == bus.rd2_addr && bus.rd2_addr != '0) rd2_next = bus.wr1_data;
    if (bus.RegW2 && bus.wr2_addr == bus.rd2_addr && bus.rd2_addr != '0) rd2_next = bus.wr2_data;
`else
`endif
  end

  // Registered read data, held while the read strobe is low
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      rd1_q <= '0;
      rd2_q <= '0;
    end else begin
      if (bus.RegR1) rd1_q <= rd1_next;
      if (bus.RegR2) rd2_q <= rd2_next;
    end
  end

  assign bus.rd1_data    = rd1_q;
  assign bus.rd2_data    = rd2_q;
  assign bus.sp          = sp_w;
  assign bus.stack_full  = full_w;
  assign bus.stack_empty = empty_w;
  assign bus.stack_err   = err_w;

endmodule

// File: tb/tb_reg_file_shadow.sv
// Directed bench for reg_file_shadow: reads/writes, port priority,
// backup/restore round trips, stack boundaries and asynchronous reset.
module tb_reg_file_shadow;

  logic clk;
  logic Reset;
  int   checks;
  int   errors;

  reg_file_shadow_if bus ();

  reg_file_shadow dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drivers
  task automatic idle();
    bus.RegR1    = 1'b0;
    bus.RegR2    = 1'b0;
    bus.rd1_addr = '0;
    bus.rd2_addr = '0;
    bus.RegW1    = 1'b0;
    bus.RegW2    = 1'b0;
    bus.wr1_addr = '0;
    bus.wr2_addr = '0;
    bus.wr1_data = '0;
    bus.wr2_data = '0;
    bus.backup   = 1'b0;
    bus.restore  = 1'b0;
  endtask

  // One clock edge; returns 1 time unit after it, then clears all strobes
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic write1(input logic [2:0] a, input logic [15:0] d);
    bus.RegW1 = 1'b1; bus.wr1_addr = a; bus.wr1_data = d;
  endtask

  task automatic write2(input logic [2:0] a, input logic [15:0] d);
    bus.RegW2 = 1'b1; bus.wr2_addr = a; bus.wr2_data = d;
  endtask

  task automatic read_both(input logic [2:0] a1, input logic [2:0] a2);
    bus.RegR1 = 1'b1; bus.rd1_addr = a1;
    bus.RegR2 = 1'b1; bus.rd2_addr = a2;
    tick();
  endtask

  // Scoreboard check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [15:0] bypass_exp;

  initial begin
    checks = 0;
    errors = 0;
    idle();
`ifdef REGFILE_BYPASS_EN
    bypass_exp = 16'h2222;
`else
    bypass_exp = 16'h0000;
`endif

    // Reset state
    Reset = 1'b1;
    #12;
    check("rst_rd1", 32'(bus.rd1_data), 32'h0);
    check("rst_rd2", 32'(bus.rd2_data), 32'h0);
    check("rst_sp", 32'(bus.sp), 32'd0);
    check("rst_empty", 32'(bus.stack_empty), 32'd1);
    check("rst_full", 32'(bus.stack_full), 32'd0);
    check("rst_err", 32'(bus.stack_err), 32'd0);
    Reset = 1'b0;
    @(posedge clk); #1;

    // Write via port 2, read back with one cycle latency; r0 reads zero
    write2(3'd3, 16'hBEEF);
    tick();
    read_both(3'd3, 3'd0);
    check("rd_r3", 32'(bus.rd1_data), 32'hBEEF);
    check("rd_r0", 32'(bus.rd2_data), 32'h0);

    // Writes to r0 are discarded
    write1(3'd0, 16'h1234);
    write2(3'd0, 16'h5678);
    tick();
    read_both(3'd0, 3'd3);
    check("r0_after_wr", 32'(bus.rd1_data), 32'h0);
    check("r3_hold_val", 32'(bus.rd2_data), 32'hBEEF);

    // Both ports to r5, port 2 wins; same-cycle read sees old value (or bypass)
    write1(3'd5, 16'h1111);
    write2(3'd5, 16'h2222);
    bus.RegR1 = 1'b1; bus.rd1_addr = 3'd5;
    tick();
    check("same_cyc_r5", 32'(bus.rd1_data), 32'(bypass_exp));
    bus.RegR2 = 1'b1; bus.rd2_addr = 3'd5;
    bus.rd1_addr = 3'd3;
    tick();
    check("r5_port2_win", 32'(bus.rd2_data), 32'h2222);
    check("rd1_hold", 32'(bus.rd1_data), 32'(bypass_exp));

    // Backup/restore round trip
    write1(3'd1, 16'h00AA);
    tick();
    bus.backup = 1'b1;
    tick();
    check("bk_sp1", 32'(bus.sp), 32'd1);
    write1(3'd1, 16'h0055);
    tick();
    read_both(3'd1, 3'd5);
    check("r1_new", 32'(bus.rd1_data), 32'h0055);
    bus.restore = 1'b1;
    tick();
    check("rs_sp0", 32'(bus.sp), 32'd0);
    check("rs_err0", 32'(bus.stack_err), 32'd0);
    read_both(3'd1, 3'd3);
    check("r1_restored", 32'(bus.rd1_data), 32'h00AA);

    // Four backups, each with a same-cycle write to r1 (frame keeps pre-write value)
    for (int k = 0; k < 4; k++) begin
      bus.backup = 1'b1;
      write1(3'd1, 16'(16'h0011 * (k + 1)));
      tick();
    end
    check("full_sp4", 32'(bus.sp), 32'd4);
    check("full_flag", 32'(bus.stack_full), 32'd1);
    check("full_err0", 32'(bus.stack_err), 32'd0);
    bus.backup = 1'b1;
    tick();
    check("ovf_sp4", 32'(bus.sp), 32'd4);
    check("ovf_err", 32'(bus.stack_err), 32'd1);

    // First restore with a write to r2 on top: r1=0033 from frame, r2=7777
    bus.restore = 1'b1;
    write2(3'd2, 16'h7777);
    tick();
    read_both(3'd1, 3'd2);
    check("pop3_r1", 32'(bus.rd1_data), 32'h0033);
    check("pop3_r2", 32'(bus.rd2_data), 32'h7777);
    for (int k = 0; k < 3; k++) begin
      bus.restore = 1'b1;
      tick();
    end
    check("empty_sp0", 32'(bus.sp), 32'd0);
    check("empty_flag", 32'(bus.stack_empty), 32'd1);
    read_both(3'd1, 3'd2);
    check("pop0_r1", 32'(bus.rd1_data), 32'h00AA);
    check("pop0_r2", 32'(bus.rd2_data), 32'h0);

    // Underflow leaves the live registers alone
    bus.restore = 1'b1;
    write1(3'd4, 16'h0404);
    tick();
    check("udf_sp0", 32'(bus.sp), 32'd0);
    read_both(3'd1, 3'd4);
    check("udf_r1", 32'(bus.rd1_data), 32'h00AA);
    check("udf_r4", 32'(bus.rd2_data), 32'h0404);
    read_both(3'd3, 3'd5);
    check("udf_r3", 32'(bus.rd1_data), 32'hBEEF);
    check("udf_r5", 32'(bus.rd2_data), 32'h2222);
    check("err_sticky", 32'(bus.stack_err), 32'd1);

    // Clear error, then backup+restore together with sp=1
    Reset = 1'b1; #2; Reset = 1'b0;
    @(posedge clk); #1;
    check("rst2_err", 32'(bus.stack_err), 32'd0);
    bus.backup = 1'b1;
    tick();
    check("cf_sp1_pre", 32'(bus.sp), 32'd1);
    check("cf_err_pre", 32'(bus.stack_err), 32'd0);
    bus.backup  = 1'b1;
    bus.restore = 1'b1;
    tick();
    check("cf_sp1", 32'(bus.sp), 32'd1);
    check("cf_err", 32'(bus.stack_err), 32'd1);

    // Reach sp=2 with data in the read registers, then reset between edges
    write1(3'd4, 16'h4444);
    bus.backup = 1'b1;
    tick();
    check("mid_sp2", 32'(bus.sp), 32'd2);
    read_both(3'd4, 3'd4);
    check("mid_r4", 32'(bus.rd1_data), 32'h4444);
    #3;
    Reset = 1'b1;
    #1;
    check("async_sp", 32'(bus.sp), 32'd0);
    check("async_rd1", 32'(bus.rd1_data), 32'h0);
    check("async_rd2", 32'(bus.rd2_data), 32'h0);
    check("async_err", 32'(bus.stack_err), 32'd0);
    check("async_empty", 32'(bus.stack_empty), 32'd1);
    #2;
    Reset = 1'b0;
    @(posedge clk); #1;
    read_both(3'd4, 3'd3);
    check("post_r4", 32'(bus.rd1_data), 32'h0);
    check("post_r3", 32'(bus.rd2_data), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
